serial_magnitude_comparator: RTL

Multi-cycle magnitude comparator controller for WIDTH-bit operands. It sequences a single 2-bit compare slice (eq/gt/lt) over the operands, two bits per clock, MSB first. It terminates early on the first unequal slice and supports signed or unsigned comparison. It sits beside the combinational comparators as the area-lean option for wide operands, with a start/busy/done handshake toward the requesting controller.

---
 rtl/serial_magnitude_comparator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: one 2-bit eq/gt/lt slice stepped MSB-first
// over WIDTH-bit operands, with early exit on the first unequal slice.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned N      = WIDTH / 2;
  localparam int unsigned CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  // Signed MSB slice: inverting the sign bit maps -2..1 onto 0..3 in order.
  logic       flip;
  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       slice_gt;
  logic       slice_lt;

  always_comb begin
    flip     = sgn_q && (k_q == '0);
    slice_a  = {sa_q[WIDTH-1] ^ flip, sa_q[WIDTH-2]};
    slice_b  = {sb_q[WIDTH-1] ^ flip, sb_q[WIDTH-2]};
    slice_gt = slice_a > slice_b;
    slice_lt = slice_a < slice_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sgn_q   <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sgn_q   <= sgn_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Next-state and registered-output logic; done is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sgn_d   = sgn_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sgn_d   = signed_mode;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (slice_gt || slice_lt) begin
          gt_d    = slice_gt;
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (k_q == K_LAST) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sa_d = sa_q << 2;
          sb_d = sb_q << 2;
          k_d  = k_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule
